sb_rx_fsm: RTL and testbench
============================

# sb_rx_fsm

Sideband receive controller: the receive-side counterpart of the sideband transmit FSM. Consumes 64-bit words from the sideband deserializer, detects the SBINIT clock pattern on LTSM request, and reassembles header-only or header+data packets. Completed packets are parity-checked and held for the LTSM/message decoder under a valid/ack handshake.

## Interface
- PATTERN_DET_COUNT, 2, consecutive pattern words required to declare pattern detected (legal ≥1)
- SB_PATTERN, 64'hAAAA_AAAA_AAAA_AAAA, SBINIT clock pattern word
- DATA_OPCODE, 5'b11011, header opcode (header[4:0]) indicating a 64-bit data word follows

- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_pattern_detect_en  input  1  level; LTSM requests pattern search
- i_word_valid  input  1  one-cycle strobe, i_word holds a new deserialized word
- i_word  input  64  deserialized sideband word
- i_msg_ack  input  1  consumer accepts held message
- o_pattern_detected  output  1  one-cycle pulse, pattern found
- o_msg_valid  output  1  level; o_header/o_data/o_has_data valid
- o_header  output  64  captured header
- o_data  output  64  captured data (0 when no data)
- o_has_data  output  1  message carried a data word
- o_parity_err  output  1  one-cycle pulse, packet dropped for parity
- o_overflow  output  1  one-cycle pulse, word dropped while a message was held
- o_busy  output  1  FSM not in IDLE

## Operation
- States: IDLE, PATTERN_DET, WAIT_DATA, DELIVER.
- IDLE: i_pattern_detect_en=1 → PATTERN_DET, counter cleared (takes priority over i_word_valid same cycle; that word is evaluated as a pattern word). Else i_word_valid=1: if i_word==SB_PATTERN discard, stay IDLE; else capture as header; header[4:0]==DATA_OPCODE → WAIT_DATA, else parity check → DELIVER or drop.
- PATTERN_DET: per i_word_valid, word==SB_PATTERN → count+1, else count→0. Count reaching PATTERN_DET_COUNT → pulse o_pattern_detected, count→0, → IDLE. i_pattern_detect_en=0 → IDLE, count cleared, no pulse (if a matching final word arrives the same cycle, no pulse). Counter width $clog2(PATTERN_DET_COUNT+1); never wraps.
- WAIT_DATA: next i_word_valid captures data unconditionally (pattern value included), then parity check. No timeout.
- Parity: CP = header[62] must equal ^header[61:0]; DP = header[63] must equal ^data[63:0] when data present, else must be 0. Any mismatch → pulse o_parity_err, o_msg_valid stays 0, → IDLE. Data word always consumed before the check.
- DELIVER: o_msg_valid=1, o_header/o_data/o_has_data stable until i_msg_ack=1; then → IDLE, o_msg_valid=0. Any i_word_valid in DELIVER (including the ack cycle) → word dropped, o_overflow pulse.
- i_pattern_detect_en ignored in WAIT_DATA and DELIVER; honored on return to IDLE if still high.
- Reset mid-operation: all state, counter and captured words cleared immediately; partial packet discarded.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- All outputs registered.
- Header-only: o_msg_valid rises the cycle after the header strobe. Header+data: rises the cycle after the data strobe. o_parity_err pulses at that same cycle instead.
- o_pattern_detected pulses the cycle after the PATTERN_DET_COUNT-th consecutive matching strobe.
- Ack in cycle N → o_msg_valid=0, state IDLE in N+1; earliest next header accepted at N+1.
- o_busy=1 in the cycle state≠IDLE (follows registered state).
- Non-consecutive strobes (gaps of i_word_valid=0) do not break pattern consecutiveness; only non-matching words do.

## Test plan
- Pattern: enable=1, three SB_PATTERN words → o_pattern_detected pulse one cycle after the 2nd strobe, state IDLE; 3rd word discarded silently.
- Pattern break: enable=1, words PAT, 64'h0, PAT, PAT → single pulse after 4th strobe only; deassert enable after one PAT → no pulse, counter 0.
- Header-only: header opcode 5'b10010 with correct CP, DP=0 → o_msg_valid=1 next cycle, o_has_data=0, o_data=0; held 5 cycles without ack; ack → valid low next cycle.
- Header+data: opcode 5'b11011, data 64'h0123_4567_89AB_CDEF, correct CP/DP → o_msg_valid with o_has_data=1 and exact header/data one cycle after data strobe.
- Parity: flip header[62] → o_parity_err pulse, no o_msg_valid; bad DP on data packet → error after data word, next header decodes normally.
- Overflow/reset: word strobe during DELIVER and during the ack cycle → o_overflow pulses, held message unchanged; assert i_rst_n=0 in WAIT_DATA → all outputs 0, next word treated as header.

Source files
------------

// File: rtl/sb_rx_fsm.sv
// Sideband receive controller: SBINIT pattern detection and
// header/data packet reassembly with parity check and valid/ack delivery.
module sb_rx_fsm #(
    parameter int unsigned PATTERN_DET_COUNT = 2,
    parameter logic [63:0] SB_PATTERN        = 64'hAAAA_AAAA_AAAA_AAAA,
    parameter logic [4:0]  DATA_OPCODE       = 5'b11011
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pattern_detect_en,
    input  logic        i_word_valid,
    input  logic [63:0] i_word,
    input  logic        i_msg_ack,
    output logic        o_pattern_detected,
    output logic        o_msg_valid,
    output logic [63:0] o_header,
    output logic [63:0] o_data,
    output logic        o_has_data,
    output logic        o_parity_err,
    output logic        o_overflow,
    output logic        o_busy
);

    localparam int unsigned CNT_W = $clog2(PATTERN_DET_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PATTERN_DET_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        PATTERN_DET,
        WAIT_DATA,
        DELIVER
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [63:0]      hdr_q;
    logic [63:0]      hdr_d;
    logic [63:0]      header_d;
    logic [63:0]      data_d;
    logic             has_data_d;
    logic             pdet_d;
    logic             perr_d;
    logic             ovf_d;

    logic             pat_match;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_hit;
    logic             hdr_cp_ok;
    logic             in_cp_ok;

    function automatic logic cp_ok(input logic [63:0] h);
        return h[62] == ^h[61:0];
    endfunction

    assign pat_match = (i_word == SB_PATTERN);
    // A search entered from IDLE starts from zero even if a stale count remains.
    assign cnt_base  = (state_q == IDLE) ? '0 : cnt_q;
    assign cnt_inc   = cnt_base + 1'b1;
    assign cnt_hit   = i_word_valid && pat_match && (cnt_inc == CNT_MAX);
    assign hdr_cp_ok = cp_ok(hdr_q);
    assign in_cp_ok  = cp_ok(i_word);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        header_d   = o_header;
        data_d     = o_data;
        has_data_d = o_has_data;
        pdet_d     = 1'b0;
        perr_d     = 1'b0;
        ovf_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_pattern_detect_en) begin
                    state_d = PATTERN_DET;
                    cnt_d   = '0;
                    if (cnt_hit) begin
                        pdet_d  = 1'b1;
                        state_d = IDLE;
                    end else if (i_word_valid) begin
                        cnt_d = pat_match ? cnt_inc : '0;
                    end
                end else if (i_word_valid && !pat_match) begin
                    hdr_d = i_word;
                    if (i_word[4:0] == DATA_OPCODE) begin
                        state_d = WAIT_DATA;
                    end else if (in_cp_ok && !i_word[63]) begin
                        state_d    = DELIVER;
                        header_d   = i_word;
                        data_d     = '0;
                        has_data_d = 1'b0;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            PATTERN_DET: begin
                if (!i_pattern_detect_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_hit) begin
                    pdet_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (i_word_valid) begin
                    cnt_d = pat_match ? cnt_inc : '0;
                end
            end
            WAIT_DATA: begin
                if (i_word_valid) begin
                    if (hdr_cp_ok && (hdr_q[63] == ^i_word)) begin
                        state_d    = DELIVER;
                        header_d   = hdr_q;
                        data_d     = i_word;
                        has_data_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        perr_d  = 1'b1;
                    end
                end
            end
            DELIVER: begin
                ovf_d = i_word_valid;
                if (i_msg_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            hdr_q              <= '0;
            o_header           <= '0;
            o_data             <= '0;
            o_has_data         <= 1'b0;
            o_msg_valid        <= 1'b0;
            o_busy             <= 1'b0;
            o_pattern_detected <= 1'b0;
            o_parity_err       <= 1'b0;
            o_overflow         <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            hdr_q              <= hdr_d;
            o_header           <= header_d;
            o_data             <= data_d;
            o_has_data         <= has_data_d;
            o_msg_valid        <= (state_d == DELIVER);
            o_busy             <= (state_d != IDLE);
            o_pattern_detected <= pdet_d;
            o_parity_err       <= perr_d;
            o_overflow         <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sb_rx_fsm.sv
// Bench for sb_rx_fsm: directed vector table, hand sequences and
// randomized traffic against a packet-level reference model.
module tb_sb_rx_fsm;

    localparam logic [63:0] PAT   = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [4:0]  OPC   = 5'b11011;
    localparam int          NDET  = 2;
    localparam logic [63:0] H1    = 64'h0000_0000_0000_0012;
    localparam logic [63:0] H1BAD = 64'h4000_0000_0000_0012;
    localparam logic [63:0] H2    = 64'h0000_0000_0000_001B;
    localparam logic [63:0] H2BAD = 64'h8000_0000_0000_001B;
    localparam logic [63:0] D2    = 64'h0123_4567_89AB_CDEF;

    localparam int PH_IDLE = 0;
    localparam int PH_PAT  = 1;
    localparam int PH_DATA = 2;
    localparam int PH_DEL  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wv;
    logic [63:0] word;
    logic        ack;
    logic        pdet;
    logic        mvalid;
    logic [63:0] header;
    logic [63:0] data;
    logic        has_data;
    logic        perr;
    logic        ovf;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sb_rx_fsm dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_pattern_detect_en(en),
        .i_word_valid       (wv),
        .i_word             (word),
        .i_msg_ack          (ack),
        .o_pattern_detected (pdet),
        .o_msg_valid        (mvalid),
        .o_header           (header),
        .o_data             (data),
        .o_has_data         (has_data),
        .o_parity_err       (perr),
        .o_overflow         (ovf),
        .o_busy             (busy)
    );

    // Reference model: packet phase, run length of matching words, held message.
    int          phase;
    int          run;
    logic [63:0] m_hdr;
    logic [63:0] m_dat;
    logic [63:0] m_pend;
    bit          m_has;
    bit          m_pd;
    bit          m_pe;
    bit          m_ov;

    function automatic void model_reset();
        phase  = PH_IDLE;
        run    = 0;
        m_hdr  = '0;
        m_dat  = '0;
        m_pend = '0;
        m_has  = 0;
        m_pd   = 0;
        m_pe   = 0;
        m_ov   = 0;
    endfunction

    function automatic void pat_word(input logic [63:0] w);
        run = (w == PAT) ? run + 1 : 0;
        if (run == NDET) begin
            m_pd  = 1;
            run   = 0;
            phase = PH_IDLE;
        end
    endfunction

    function automatic void finish_pkt(input logic [63:0] h, input bit has,
                                       input logic [63:0] d);
        int cp_exp;
        int dp_exp;
        cp_exp = $countones(h[61:0]) % 2;
        dp_exp = has ? $countones(d) % 2 : 0;
        if (int'(h[62]) == cp_exp && int'(h[63]) == dp_exp) begin
            phase = PH_DEL;
            m_hdr = h;
            m_dat = has ? d : 64'd0;
            m_has = has;
        end else begin
            m_pe  = 1;
            phase = PH_IDLE;
        end
    endfunction

    function automatic void model_step(input bit e, input bit v,
                                       input logic [63:0] w, input bit a);
        m_pd = 0;
        m_pe = 0;
        m_ov = 0;
        case (phase)
            PH_IDLE: begin
                if (e) begin
                    run   = 0;
                    phase = PH_PAT;
                    if (v) pat_word(w);
                end else if (v && w != PAT) begin
                    m_pend = w;
                    if (w[4:0] == OPC) phase = PH_DATA;
                    else finish_pkt(w, 0, 64'd0);
                end
            end
            PH_PAT: begin
                if (!e) begin
                    run   = 0;
                    phase = PH_IDLE;
                end else if (v) begin
                    pat_word(w);
                end
            end
            PH_DATA: if (v) finish_pkt(m_pend, 1, w);
            default: begin
                if (v) m_ov = 1;
                if (a) phase = PH_IDLE;
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit e, input bit v, input logic [63:0] w,
                        input bit a);
        en   = e;
        wv   = v;
        word = w;
        ack  = a;
        model_step(e, v, w, a);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pdet"}, 64'(pdet), 64'(m_pd));
        chk({tag, " perr"}, 64'(perr), 64'(m_pe));
        chk({tag, " ovf"}, 64'(ovf), 64'(m_ov));
        chk({tag, " mvalid"}, 64'(mvalid), 64'(phase == PH_DEL));
        chk({tag, " busy"}, 64'(busy), 64'(phase != PH_IDLE));
        if (phase == PH_DEL) begin
            chk({tag, " has_data"}, 64'(has_data), 64'(m_has));
            chk({tag, " header"}, header, m_hdr);
            chk({tag, " data"}, data, m_dat);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " pdet"}, 64'(pdet), 64'd0);
        chk({tag, " mvalid"}, 64'(mvalid), 64'd0);
        chk({tag, " header"}, header, 64'd0);
        chk({tag, " data"}, data, 64'd0);
        chk({tag, " has_data"}, 64'(has_data), 64'd0);
        chk({tag, " perr"}, 64'(perr), 64'd0);
        chk({tag, " ovf"}, 64'(ovf), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    typedef struct packed {
        logic        en;
        logic        wv;
        logic [63:0] w;
        logic        ack;
        logic        pd;
        logic        mv;
        logic        pe;
        logic        ov;
        logic        busy;
        logic        has;
        logic [63:0] hdr;
        logic [63:0] dat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit e, input bit v, input logic [63:0] w,
                                input bit a, input bit pd, input bit mv,
                                input bit pe, input bit ov, input bit bz,
                                input bit hs, input logic [63:0] h,
                                input logic [63:0] d);
        vec_t t;
        t.en   = e;
        t.wv   = v;
        t.w    = w;
        t.ack  = a;
        t.pd   = pd;
        t.mv   = mv;
        t.pe   = pe;
        t.ov   = ov;
        t.busy = bz;
        t.has  = hs;
        t.hdr  = h;
        t.dat  = d;
        vecs.push_back(t);
    endfunction

    initial begin
        //  en wv word   ack pd mv pe ov bz hs hdr data
        add(1, 1, PAT,   0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 1, PAT,   0,  1, 0, 0, 0, 0, 0, 0,  0);
        add(0, 1, PAT,   0,  0, 0, 0, 0, 0, 0, 0,  0);
        add(1, 0, 0,     0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 1, PAT,   0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 1, 0,     0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 0, 0,     0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 1, PAT,   0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 1, PAT,   0,  1, 0, 0, 0, 0, 0, 0,  0);
        add(1, 1, PAT,   0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(0, 1, PAT,   0,  0, 0, 0, 0, 0, 0, 0,  0);
        add(1, 1, PAT,   0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 1, PAT,   0,  1, 0, 0, 0, 0, 0, 0,  0);
        add(0, 0, 0,     0,  0, 0, 0, 0, 0, 0, 0,  0);
        add(0, 1, H1,    0,  0, 1, 0, 0, 1, 0, H1, 0);
        add(0, 0, 0,     0,  0, 1, 0, 0, 1, 0, H1, 0);
        add(0, 0, 0,     0,  0, 1, 0, 0, 1, 0, H1, 0);
        add(0, 0, 0,     0,  0, 1, 0, 0, 1, 0, H1, 0);
        add(0, 0, 0,     0,  0, 1, 0, 0, 1, 0, H1, 0);
        add(0, 0, 0,     1,  0, 0, 0, 0, 0, 0, 0,  0);
        add(0, 1, H2,    0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(0, 0, 0,     0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(0, 1, D2,    0,  0, 1, 0, 0, 1, 1, H2, D2);
        add(0, 0, 0,     1,  0, 0, 0, 0, 0, 0, 0,  0);
        add(0, 1, H1BAD, 0,  0, 0, 1, 0, 0, 0, 0,  0);
        add(0, 1, H2BAD, 0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(0, 1, D2,    0,  0, 0, 1, 0, 0, 0, 0,  0);
        add(0, 1, H1,    0,  0, 1, 0, 0, 1, 0, H1, 0);
        add(0, 1, PAT,   0,  0, 1, 0, 1, 1, 0, H1, 0);
        add(0, 1, 64'h5, 1,  0, 0, 0, 1, 0, 0, 0,  0);
        add(0, 1, H2,    0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 0, 0,     0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(1, 1, PAT,   0,  0, 1, 0, 0, 1, 1, H2, PAT);
        add(1, 0, 0,     1,  0, 0, 0, 0, 0, 0, 0,  0);
        add(1, 0, 0,     0,  0, 0, 0, 0, 1, 0, 0,  0);
        add(0, 0, 0,     0,  0, 0, 0, 0, 0, 0, 0,  0);

        rst_n = 1'b0;
        en    = 1'b0;
        wv    = 1'b0;
        word  = '0;
        ack   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].wv, vecs[i].w, vecs[i].ack);
            chk($sformatf("vec%0d pdet", i), 64'(pdet), 64'(vecs[i].pd));
            chk($sformatf("vec%0d mvalid", i), 64'(mvalid), 64'(vecs[i].mv));
            chk($sformatf("vec%0d perr", i), 64'(perr), 64'(vecs[i].pe));
            chk($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vecs[i].ov));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].busy));
            if (vecs[i].mv) begin
                chk($sformatf("vec%0d has", i), 64'(has_data), 64'(vecs[i].has));
                chk($sformatf("vec%0d hdr", i), header, vecs[i].hdr);
                chk($sformatf("vec%0d data", i), data, vecs[i].dat);
            end
        end

        // Reset asserted while waiting for a data word.
        step(0, 1, H2, 0);
        chk("wait_data busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, H1, 0);
        chk("post-reset mvalid", 64'(mvalid), 64'd1);
        chk("post-reset has", 64'(has_data), 64'd0);
        chk("post-reset hdr", header, H1);
        step(0, 0, 0, 1);
        check_model("post-reset ack");

        // Randomized traffic against the model.
        begin
            bit e;
            e = 0;
            for (int c = 0; c < 3000; c++) begin
                logic [63:0] w;
                int          sel;
                if ($urandom_range(0, 7) == 0) e = ~e;
                sel = $urandom_range(0, 9);
                w   = {$urandom, $urandom};
                case (sel)
                    0, 1, 2: w = PAT;
                    3: w = H1;
                    4: w = H2;
                    5: w = H1BAD;
                    6: w = H2BAD;
                    8: w[4:0] = OPC;
                    9: w = D2;
                    default: ;
                endcase
                step(e, $urandom_range(0, 1) == 1, w, $urandom_range(0, 2) == 0);
                check_model($sformatf("rand%0d", c));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
